// File: rtl/issue_sched_pkg.sv
// rtl/issue_sched_pkg.sv - shared types and constants for the issue scheduler
package issue_sched_pkg;

    typedef enum logic [1:0] {
        ISS_FIXED   = 2'd0,
        ISS_RR      = 2'd1,
        ISS_BRFIRST = 2'd2
    } issue_mode_t;

    localparam int FU_ALU = 0;
    localparam int FU_BRU = 1;
    localparam int FU_LSU = 2;
    localparam int N_FU   = 3;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] ps1;
        logic [5:0] ps2;
        logic [5:0] pd;
    } rs_entry_t;

endpackage

// File: rtl/issue_sched_rr_arbiter.sv
// rtl/issue_sched_rr_arbiter.sv - combinational rotate-priority one-hot picker
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_sched.sv
// rtl/issue_sched.sv - RS head select with fixed/rr/branch-first modes and one-deep issue stage
module issue_sched
    import issue_sched_pkg::*;
#(
    parameter int N_REQ      = N_FU,
    parameter int ENTRY_W    = $bits(rs_entry_t),
    parameter int FLUSH_HOLD = 2,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic [1:0]               mode_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ*ENTRY_W-1:0] req_entry_i,
    input  logic [N_REQ-1:0]         fu_busy_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic                     iss_valid_o,
    output logic [N_REQ-1:0]         iss_fu_o,
    output logic [ENTRY_W-1:0]       iss_entry_o,
    output logic [N_REQ*CNT_W-1:0]   grant_cnt_o
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = $clog2(FLUSH_HOLD + 1);

    logic [PW-1:0]              rr_ptr;
    logic [HW-1:0]              hold_cnt;
    logic [N_REQ-1:0][CNT_W-1:0] cnt;

    logic [N_REQ-1:0]   elig;
    logic [N_REQ-1:0]   gnt_fixed;
    logic [N_REQ-1:0]   gnt_rr;
    logic [N_REQ-1:0]   bru_oh;
    logic               gnt_any;
    logic [PW-1:0]      gnt_idx;
    logic [PW-1:0]      ptr_next;
    logic [ENTRY_W-1:0] sel_entry;

    // Gating by rst keeps grant_o low while reset is held, since it is purely combinational.
    assign elig = req_valid_i & ~fu_busy_i
                & {N_REQ{(hold_cnt == '0) && !flush_i && !rst}};

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb_fixed (
        .req (elig),
        .ptr ('0),
        .gnt (gnt_fixed)
    );

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb_rr (
        .req (elig),
        .ptr (rr_ptr),
        .gnt (gnt_rr)
    );

    always_comb begin
        bru_oh         = '0;
        bru_oh[FU_BRU] = 1'b1;
        case (issue_mode_t'(mode_i))
            ISS_RR:      grant_o = gnt_rr;
            ISS_BRFIRST: grant_o = elig[FU_BRU] ? bru_oh : gnt_rr;
            default:     grant_o = gnt_fixed;
        endcase
    end

    always_comb begin
        gnt_any   = |grant_o;
        gnt_idx   = '0;
        sel_entry = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_o[k]) begin
                gnt_idx   = PW'(k);
                sel_entry = req_entry_i[k*ENTRY_W +: ENTRY_W];
            end
        end
        ptr_next = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= '0;
            hold_cnt    <= '0;
            iss_valid_o <= 1'b0;
            iss_fu_o    <= '0;
            iss_entry_o <= '0;
        end else if (flush_i) begin
            hold_cnt    <= HW'(FLUSH_HOLD);
            iss_valid_o <= 1'b0;
            iss_fu_o    <= '0;
            iss_entry_o <= '0;
        end else begin
            if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
            iss_valid_o <= gnt_any;
            iss_fu_o    <= grant_o;
            if (gnt_any) begin
                rr_ptr      <= ptr_next;
                iss_entry_o <= sel_entry;
            end
        end
    end

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (grant_o[k] && (cnt[k] != '1)) begin
                    cnt[k] <= cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    assign grant_cnt_o = cnt;

endmodule
